// File: rtl/q_sys_cali_ram_arbiter.sv
// Calibration RAM arbiter: datapath fetches have priority over Avalon host accesses, bounded by a streak limit.
// Optional build macro CALI_ARB_INIT_SWEEP_EN fills the RAM with INIT_VALUE after every reset.
module q_sys_cali_ram_arbiter #(
   parameter int                ADDR_W        = 9,
   parameter int                DATA_W        = 8,
   parameter int                DP_MAX_STREAK = 8,
   parameter logic [DATA_W-1:0] INIT_VALUE    = 8'h80
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] av_address,
   input  logic              av_read,
   input  logic              av_write,
   input  logic [DATA_W-1:0] av_writedata,
   output logic              av_waitrequest,
   output logic [DATA_W-1:0] av_readdata,
   output logic              av_readdatavalid,
   input  logic              cfg_lock,
   output logic [7:0]        lock_drop_cnt,
   input  logic              dp_req,
   input  logic [ADDR_W-1:0] dp_chan,
   output logic              dp_ready,
   output logic [DATA_W-1:0] dp_coef,
   output logic [ADDR_W-1:0] dp_coef_chan,
   output logic              dp_valid,
   output logic              busy,
   output logic [ADDR_W-1:0] ram_address,
   output logic              ram_chipselect,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_writedata,
   input  logic [DATA_W-1:0] ram_readdata
);

`ifdef CALI_ARB_INIT_SWEEP_EN
   localparam bit SWEEP_EN = 1'b1;
`else
   localparam bit SWEEP_EN = 1'b0;
`endif
   localparam logic [7:0]        STREAK_MAX = 8'(DP_MAX_STREAK);
   localparam logic [ADDR_W-1:0] SWEEP_LAST = {ADDR_W{1'b1}};

   typedef enum logic {ST_INIT, ST_IDLE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] sweep_addr_q, sweep_addr_d;
   logic [7:0]        streak_q, streak_d;
   logic [7:0]        lock_cnt_q, lock_cnt_d;
   logic              cmd_cs_q, cmd_cs_d;
   logic              cmd_we_q, cmd_we_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
   logic              s1_rd_q, s1_rd_d;
   logic              s1_dp_q, s1_dp_d;
   logic              s2_rd_q, s2_rd_d;
   logic              s2_dp_q, s2_dp_d;
   logic [ADDR_W-1:0] s2_chan_q, s2_chan_d;
   logic              dp_valid_q, dp_valid_d;
   logic              av_rdv_q, av_rdv_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [ADDR_W-1:0] out_chan_q, out_chan_d;

   logic host_pending;
   logic grant_en;
   logic dp_grant;
   logic host_grant;

   // Grants are combinational so the requester sees its handshake in the same cycle.
   assign host_pending = av_read | av_write;
   assign grant_en     = (state_q == ST_IDLE) & ~reset;
   assign dp_grant     = grant_en & dp_req & ~(host_pending & (streak_q == STREAK_MAX));
   assign host_grant   = grant_en & host_pending & ~dp_grant;

   always_comb begin
      state_d      = state_q;
      sweep_addr_d = sweep_addr_q;
      streak_d     = streak_q;
      lock_cnt_d   = lock_cnt_q;
      cmd_cs_d     = 1'b0;
      cmd_we_d     = 1'b0;
      cmd_addr_d   = cmd_addr_q;
      cmd_wdata_d  = cmd_wdata_q;
      s1_rd_d      = 1'b0;
      s1_dp_d      = 1'b0;

      if (state_q == ST_INIT) begin
         if (SWEEP_EN) begin
            cmd_cs_d     = 1'b1;
            cmd_we_d     = 1'b1;
            cmd_addr_d   = sweep_addr_q;
            cmd_wdata_d  = INIT_VALUE;
            sweep_addr_d = sweep_addr_q + ADDR_W'(1);
            if (sweep_addr_q == SWEEP_LAST) state_d = ST_IDLE;
         end else begin
            state_d = ST_IDLE;
         end
      end

      if (dp_grant) begin
         cmd_cs_d   = 1'b1;
         cmd_addr_d = dp_chan;
         s1_rd_d    = 1'b1;
         s1_dp_d    = 1'b1;
      end else if (host_grant) begin
         if (av_write) begin
            // Locked writes complete the handshake but never reach the RAM.
            if (cfg_lock) begin
               if (lock_cnt_q != 8'hFF) lock_cnt_d = lock_cnt_q + 8'd1;
            end else begin
               cmd_cs_d    = 1'b1;
               cmd_we_d    = 1'b1;
               cmd_addr_d  = av_address;
               cmd_wdata_d = av_writedata;
            end
         end else begin
            cmd_cs_d   = 1'b1;
            cmd_addr_d = av_address;
            s1_rd_d    = 1'b1;
         end
      end

      if (!host_pending || host_grant) begin
         streak_d = 8'd0;
      end else if (dp_grant) begin
         streak_d = streak_q + 8'd1;
      end

      s2_rd_d    = s1_rd_q;
      s2_dp_d    = s1_dp_q;
      s2_chan_d  = cmd_addr_q;
      dp_valid_d = s2_rd_q & s2_dp_q;
      av_rdv_d   = s2_rd_q & ~s2_dp_q;
      out_data_d = s2_rd_q ? ram_readdata : out_data_q;
      out_chan_d = (s2_rd_q & s2_dp_q) ? s2_chan_q : out_chan_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_INIT;
         sweep_addr_q <= '0;
         streak_q     <= '0;
         lock_cnt_q   <= '0;
         cmd_cs_q     <= 1'b0;
         cmd_we_q     <= 1'b0;
         cmd_addr_q   <= '0;
         cmd_wdata_q  <= '0;
         s1_rd_q      <= 1'b0;
         s1_dp_q      <= 1'b0;
         s2_rd_q      <= 1'b0;
         s2_dp_q      <= 1'b0;
         s2_chan_q    <= '0;
         dp_valid_q   <= 1'b0;
         av_rdv_q     <= 1'b0;
         out_data_q   <= '0;
         out_chan_q   <= '0;
      end else begin
         state_q      <= state_d;
         sweep_addr_q <= sweep_addr_d;
         streak_q     <= streak_d;
         lock_cnt_q   <= lock_cnt_d;
         cmd_cs_q     <= cmd_cs_d;
         cmd_we_q     <= cmd_we_d;
         cmd_addr_q   <= cmd_addr_d;
         cmd_wdata_q  <= cmd_wdata_d;
         s1_rd_q      <= s1_rd_d;
         s1_dp_q      <= s1_dp_d;
         s2_rd_q      <= s2_rd_d;
         s2_dp_q      <= s2_dp_d;
         s2_chan_q    <= s2_chan_d;
         dp_valid_q   <= dp_valid_d;
         av_rdv_q     <= av_rdv_d;
         out_data_q   <= out_data_d;
         out_chan_q   <= out_chan_d;
      end
   end

   assign av_waitrequest   = host_pending & ~host_grant;
   assign dp_ready         = dp_grant;
   assign av_readdata      = out_data_q;
   assign av_readdatavalid = av_rdv_q;
   assign dp_coef          = out_data_q;
   assign dp_coef_chan     = out_chan_q;
   assign dp_valid         = dp_valid_q;
   assign lock_drop_cnt    = lock_cnt_q;
   assign busy             = (state_q == ST_INIT);
   assign ram_address      = cmd_addr_q;
   assign ram_chipselect   = cmd_cs_q;
   assign ram_write        = cmd_we_q;
   assign ram_writedata    = cmd_wdata_q;

endmodule

// File: tb/tb_q_sys_cali_ram_arbiter.sv
// Bench for q_sys_cali_ram_arbiter: golden memory plus grant-order scoreboard, directed and random traffic.
module tb_q_sys_cali_ram_arbiter;
   localparam int MAXS = 8;
`ifdef CALI_ARB_INIT_SWEEP_EN
   localparam int EXP_BUSY = 512;
`else
   localparam int EXP_BUSY = 1;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] av_address;
   logic       av_read, av_write;
   logic [7:0] av_writedata;
   logic       av_waitrequest;
   logic [7:0] av_readdata;
   logic       av_readdatavalid;
   logic       cfg_lock;
   logic [7:0] lock_drop_cnt;
   logic       dp_req;
   logic [8:0] dp_chan;
   logic       dp_ready;
   logic [7:0] dp_coef;
   logic [8:0] dp_coef_chan;
   logic       dp_valid;
   logic       busy;
   logic [8:0] ram_address;
   logic       ram_chipselect, ram_write;
   logic [7:0] ram_writedata;
   logic [7:0] ram_readdata;

   q_sys_cali_ram_arbiter #(.ADDR_W(9), .DATA_W(8), .DP_MAX_STREAK(MAXS), .INIT_VALUE(8'h80)) dut (
      .clk(clk), .reset(reset),
      .av_address(av_address), .av_read(av_read), .av_write(av_write), .av_writedata(av_writedata),
      .av_waitrequest(av_waitrequest), .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
      .cfg_lock(cfg_lock), .lock_drop_cnt(lock_drop_cnt),
      .dp_req(dp_req), .dp_chan(dp_chan), .dp_ready(dp_ready), .dp_coef(dp_coef),
      .dp_coef_chan(dp_coef_chan), .dp_valid(dp_valid), .busy(busy),
      .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
      .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_dp;
      logic [8:0] chan;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] mem  [0:511];
   logic [7:0] gold [0:511];
   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   int         streak = 0;
   int         m_lock = 0;
   int         m_wr   = 0;
   int         obs_wr = 0;
   bit         chk_en = 0;
   bit         dp_acc = 0;
   bit         host_acc = 0;
   logic [7:0] last_dp_coef, last_av_data;
   logic [8:0] last_dp_chan;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous single-port RAM, read-before-write.
   initial begin : ram_model
      logic [7:0] rd_tmp;
      forever begin
         @(posedge clk);
         if (ram_chipselect) begin
            rd_tmp = mem[ram_address];
            if (ram_write) mem[ram_address] = ram_writedata;
            ram_readdata <= rd_tmp;
         end
      end
   end

   initial begin : wr_observer
      forever begin
         @(negedge clk);
         if (ram_chipselect && ram_write) obs_wr++;
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   // Reference: arbitration rule, golden memory updated at acceptance, expected reads queued in grant order.
   initial begin : acceptor
      bit   hp, e_dp, e_host;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!chk_en) begin
            dp_acc   = 0;
            host_acc = 0;
         end else begin
            hp     = av_read || av_write;
            e_dp   = !reset && dp_req && !(hp && streak == MAXS);
            e_host = !reset && hp && !e_dp;
            check("dp_ready", 32'(dp_ready), 32'(e_dp));
            check("av_waitrequest", 32'(av_waitrequest), 32'(hp && !e_host));
            check("lock_drop_cnt", 32'(lock_drop_cnt), 32'(m_lock));
            if (reset) begin
               streak = 0;
               m_lock = 0;
            end else begin
               if (e_dp) begin
                  e.is_dp = 1; e.chan = dp_chan; e.data = gold[dp_chan]; e.cyc = cyc + 3;
                  sb.push_back(e);
               end
               if (e_host) begin
                  if (av_write) begin
                     if (cfg_lock) begin
                        if (m_lock < 255) m_lock++;
                     end else begin
                        gold[av_address] = av_writedata;
                        m_wr++;
                     end
                  end else begin
                     e.is_dp = 0; e.chan = av_address; e.data = gold[av_address]; e.cyc = cyc + 3;
                     sb.push_back(e);
                  end
               end
               if (!hp || e_host) streak = 0;
               else if (e_dp) streak++;
            end
            dp_acc   = e_dp;
            host_acc = e_host;
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (chk_en && (dp_valid || av_readdatavalid)) begin
            check("valid_overlap", 32'(dp_valid & av_readdatavalid), 32'd0);
            if (sb.size() == 0) begin
               check("unexpected_valid", 32'({dp_valid, av_readdatavalid}), 32'd0);
            end else begin
               e = sb.pop_front();
               check("valid_kind", 32'(dp_valid), 32'(e.is_dp));
               check("valid_latency", 32'(cyc), 32'(e.cyc));
               if (e.is_dp) begin
                  check("dp_coef", 32'(dp_coef), 32'(e.data));
                  check("dp_coef_chan", 32'(dp_coef_chan), 32'(e.chan));
                  last_dp_coef = dp_coef;
                  last_dp_chan = dp_coef_chan;
                  $display("rd dp   chan=%0d coef=0x%02h cycle=%0d", dp_coef_chan, dp_coef, cyc);
               end else begin
                  check("av_readdata", 32'(av_readdata), 32'(e.data));
                  last_av_data = av_readdata;
                  $display("rd host addr=%0d data=0x%02h cycle=%0d", e.chan, av_readdata, cyc);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      dp_req   = 0;
      av_read  = 0;
      av_write = 0;
   endtask

   task automatic host_xfer(input bit wr, input logic [8:0] a, input logic [7:0] d);
      int n = 0;
      av_address = a; av_writedata = d; av_write = wr; av_read = !wr;
      do begin
         @(posedge clk);
         n++;
      end while (!host_acc && n < 64);
      check("host_accept", 32'(host_acc), 32'd1);
      #1;
      av_read = 0; av_write = 0;
   endtask

   task automatic dp_fetch(input logic [8:0] ch);
      int n = 0;
      dp_req = 1; dp_chan = ch;
      do begin
         @(posedge clk);
         n++;
      end while (!dp_acc && n < 64);
      check("dp_accept", 32'(dp_acc), 32'd1);
      #1;
      dp_req = 0;
   endtask

   task automatic drain();
      repeat (6) tick();
      check("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1;
      @(negedge clk);
      @(posedge clk);
      #1;
      sb.delete();
`ifdef CALI_ARB_INIT_SWEEP_EN
      for (int i = 0; i < 512; i++) gold[i] = 8'h80;
`endif
      repeat (2) tick();
      reset = 0;
      repeat (EXP_BUSY + 1) tick();
   endtask

   initial begin : stim
      int         cnt, stall_bad, nz, h1, h2, n, w0, m0, r;
      bit         dd, hd;
      reset = 1; cfg_lock = 0; av_address = '0; av_writedata = '0; dp_chan = '0;
      av_read = 1; av_write = 0; dp_req = 1;
      for (int i = 0; i < 512; i++) begin
         mem[i]  = 8'($urandom);
         gold[i] = mem[i];
      end
      repeat (3) tick();
      @(negedge clk);
      check("rst_waitrequest", 32'(av_waitrequest), 32'd1);
      check("rst_dp_ready", 32'(dp_ready), 32'd0);
      check("rst_valids", 32'({dp_valid, av_readdatavalid}), 32'd0);
      check("rst_chipselect", 32'(ram_chipselect), 32'd0);
      check("rst_lock_cnt", 32'(lock_drop_cnt), 32'd0);
      tick();
`ifdef CALI_ARB_INIT_SWEEP_EN
      reset = 0;
      repeat (100) tick();
      reset = 1;
      repeat (2) tick();
`endif
      reset = 0;
      cnt = 0; stall_bad = 0;
      @(negedge clk);
      while (busy && cnt < 2000) begin
         if (dp_ready || !av_waitrequest) stall_bad++;
         cnt++;
         @(negedge clk);
      end
      tick();
      idle_inputs();
      check("busy_cycles", 32'(cnt), 32'(EXP_BUSY));
      check("busy_no_grant", 32'(stall_bad), 32'd0);
      repeat (8) tick();
`ifdef CALI_ARB_INIT_SWEEP_EN
      nz = 0;
      for (int i = 0; i < 512; i++) begin
         if (mem[i] !== 8'h80) nz++;
         gold[i] = 8'h80;
      end
      check("sweep_words", 32'(nz), 32'd0);
`endif
      chk_en = 1;

      // Datapath fetch of a known coefficient.
      host_xfer(1, 9'd5, 8'h3C);
      dp_fetch(9'd5);
      drain();
      check("fetch5_coef", 32'(last_dp_coef), 32'h3C);
      check("fetch5_chan", 32'(last_dp_chan), 32'd5);

      // Host write then readback.
      w0 = obs_wr;
      host_xfer(1, 9'd7, 8'hA5);
      host_xfer(0, 9'd7, 8'h00);
      drain();
      check("wr7_ram_writes", 32'(obs_wr - w0), 32'd1);
      check("rd7_data", 32'(last_av_data), 32'hA5);

      // Continuous datapath traffic against two host reads.
      av_address = 9'd9; av_read = 1; dp_req = 1; dp_chan = 9'($urandom_range(511));
      h1 = -1; h2 = -1;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         if (host_acc) begin
            if (h1 < 0) h1 = i;
            else h2 = i;
         end
         #1;
         if (host_acc) av_read = 0;
         if (i == 11) begin
            av_read = 1; av_address = 9'd10;
         end
         if (dp_acc) dp_chan = 9'($urandom_range(511));
      end
      idle_inputs();
      drain();
      check("streak_first_host", 32'(h1), 32'd8);
      check("streak_second_host", 32'(h2), 32'd20);

      // Locked writes are dropped and counted.
      w0 = obs_wr;
      cfg_lock = 1;
      for (int i = 0; i < 300; i++) host_xfer(1, 9'($urandom_range(31)), 8'($urandom));
      cfg_lock = 0;
      drain();
      check("lock_ram_writes", 32'(obs_wr - w0), 32'd0);
      check("lock_cnt_sat", 32'(lock_drop_cnt), 32'd255);
      host_xfer(0, 9'd7, 8'h00);
      for (int i = 0; i < 4; i++) host_xfer(0, 9'(i), 8'h00);
      drain();

      // Same-cycle datapath read and host write to one address.
      host_xfer(1, 9'd3, 8'h11);
      drain();
      dp_req = 1; dp_chan = 9'd3;
      av_write = 1; av_read = 0; av_address = 9'd3; av_writedata = 8'h22;
      dd = 0; hd = 0; n = 0;
      while (!(dd && hd) && n < 64) begin
         @(posedge clk);
         n++;
         if (dp_acc) dd = 1;
         if (host_acc) hd = 1;
         #1;
         if (dd) dp_req = 0;
         if (hd) av_write = 0;
      end
      check("same_cycle_done", 32'(dd && hd), 32'd1);
      drain();
      check("same_cycle_old", 32'(last_dp_coef), 32'h11);
      dp_fetch(9'd3);
      drain();
      check("same_cycle_new", 32'(last_dp_coef), 32'h22);

      // Random mixed traffic on a small address window.
      w0 = obs_wr; m0 = m_wr;
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         if (!dp_req || dp_acc) begin
            dp_req  = ($urandom_range(99) < 55);
            dp_chan = 9'($urandom_range(15));
         end
         if (!(av_read || av_write) || host_acc) begin
            r = int'($urandom_range(99));
            av_read      = (r < 30) || (r >= 60 && r < 65);
            av_write     = (r >= 30 && r < 65);
            av_address   = 9'($urandom_range(15));
            av_writedata = 8'($urandom);
         end
         if ($urandom_range(99) < 3) cfg_lock = !cfg_lock;
      end
      idle_inputs();
      cfg_lock = 0;
      drain();
      check("random_ram_writes", 32'(obs_wr - w0), 32'(m_wr - m0));

      // Reset with fetches in flight.
      dp_req = 1; dp_chan = 9'd1;
      repeat (3) tick();
      do_reset();
      check("post_rst_lock_cnt", 32'(lock_drop_cnt), 32'd0);
      dp_fetch(9'd5);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
